alu_exec_unit: RTL

- Multi-cycle integer execute unit for the Execute stage.
- Consumes the 4-bit ALU operation code produced by the ALU operation selector, plus two operands, and returns a registered result with a branch-compare zero flag.
- Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle.
- Input and output each use a valid/ready handshake, so the pipeline can stall around long shifts.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_serial_shifter.sv | 66 ++++++
 rtl/alu_exec_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and state definitions for the execute unit
// Purpose: ALU operation codes shared with the ALU operation selector,
//          execute FSM states and default datapath width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLTU = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_JALR = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } exec_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - iterative one-bit-per-cycle shifter
// Purpose: holds the work register and remaining shift count. On start it
//          loads the operand and amount; every following cycle with a
//          nonzero count it shifts by one bit.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         load data/shamt/direction/fill controls
//   data          operand to shift
//   shamt         shift amount (0 leaves the shifter idle)
//   shift_left    1 = SLL, 0 = right shift
//   shift_arith   right shifts fill with the sign bit
//   done          high in the cycle whose edge produces the final value
//   data_out      value the work register takes on the next edge
module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shift_left,
    input  logic               shift_arith,
    output logic               done,
    output logic [XLEN-1:0]    data_out
);

    logic [XLEN-1:0]    work_q;
    logic [XLEN-1:0]    work_d;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic               arith_q;

    // The MSB never changes during an arithmetic right shift, so it still
    // holds the original sign bit for every step.
    always_comb begin
        work_d = work_q;
        if (left_q) begin
            work_d = {work_q[XLEN-2:0], 1'b0};
        end else begin
            work_d = {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
        end
    end

    assign done     = (cnt_q == SHAMT_W'(1));
    assign data_out = work_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (start) begin
            work_q  <= data;
            cnt_q   <= shamt;
            left_q  <= shift_left;
            arith_q <= shift_arith;
        end else if (cnt_q != '0) begin
            work_q  <= work_d;
            cnt_q   <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle integer execute unit with valid/ready
// Purpose: single-cycle logic/arithmetic ops, iterative shifts via
//          alu_serial_shifter, registered result with branch zero flag.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    request handshake (ready only in IDLE)
//   alu_control            4-bit operation code
//   op_a, op_b             operands; op_b[SHAMT_W-1:0] is the shift amount
//   out_valid / out_ready  result handshake
//   result, zero, illegal  registered outputs, stable while out_valid
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    exec_state_e        state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [XLEN-1:0]    result_q;
    logic               zero_q;
    logic               illegal_q;

    logic [XLEN-1:0]    alu_res_d;
    logic [XLEN-1:0]    sum_d;
    logic               is_shift_d;
    logic               illegal_d;
    logic [SHAMT_W-1:0] shamt_d;
    logic               accept;
    logic               sh_start;
    logic               sh_done;
    logic [XLEN-1:0]    sh_data;

    assign sum_d   = op_a + op_b;
    assign shamt_d = op_b[SHAMT_W-1:0];
    assign accept  = in_valid && in_ready_q;

    // Shift codes produce op_a here: that is the answer for shamt == 0,
    // and nonzero shifts take their result from the serial shifter.
    always_comb begin
        alu_res_d  = '0;
        is_shift_d = 1'b0;
        illegal_d  = 1'b0;
        case (alu_control)
            OP_ADD:  alu_res_d = sum_d;
            OP_SUB:  alu_res_d = op_a - op_b;
            OP_AND:  alu_res_d = op_a & op_b;
            OP_OR:   alu_res_d = op_a | op_b;
            OP_XOR:  alu_res_d = op_a ^ op_b;
            OP_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res_d  = op_a;
                is_shift_d = 1'b1;
            end
            OP_JALR: alu_res_d = {sum_d[XLEN-1:1], 1'b0};
            default: illegal_d = 1'b1;
        endcase
    end

    assign sh_start = accept && is_shift_d && (shamt_d != '0);

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (sh_start),
        .data        (op_a),
        .shamt       (shamt_d),
        .shift_left  (alu_control == OP_SLL),
        .shift_arith (alu_control == OP_SRA),
        .done        (sh_done),
        .data_out    (sh_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (sh_start) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res_d;
                            zero_q      <= (alu_res_d == '0);
                            illegal_q   <= illegal_d;
                        end
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= sh_data;
                        zero_q      <= (sh_data == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
